// File: rtl/fixed_arith_pkg.sv
// Shared types, default widths and helpers for the fixed-point multiply/divide pair.
// fixed_divider uses the same defaults so its outputs feed fixed_multiplier directly.
package fixed_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiplicand / quotient width and multiplier / divisor / remainder width.
    localparam int DEF_WIDTH_A = 32;
    localparam int DEF_WIDTH_B = 16;

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fixed_multiplier_if.sv
// Operand/result bundle for fixed_multiplier; master drives operands, slave returns the result.
interface fixed_multiplier_if
    import fixed_arith_pkg::*;
#(
    parameter int WIDTH_A = DEF_WIDTH_A,
    parameter int WIDTH_B = DEF_WIDTH_B
);
    // Handshake: init acts as valid and !busy as ready; an op is taken on a rising edge with
    // init=1 and busy=0, operands are captured on that edge only, and done pulses exactly once
    // per accepted op, on the cycle Product first shows its result.
    logic                       init;
    logic [WIDTH_A-1:0]         inMultiplicand;
    logic [WIDTH_B-1:0]         inMultiplier;
    logic [WIDTH_B-1:0]         inAddend;
    logic [WIDTH_A+WIDTH_B-1:0] Product;
    logic                       busy;
    logic                       done;

    modport master (
        output init, inMultiplicand, inMultiplier, inAddend,
        input  Product, busy, done
    );

    modport slave (
        input  init, inMultiplicand, inMultiplier, inAddend,
        output Product, busy, done
    );

endinterface

// File: rtl/fixed_mul_step.sv
// One radix-2 shift-add iteration: conditionally add A into the high half, then shift {hi,lo} right.
module fixed_mul_step
    import fixed_arith_pkg::*;
#(
    parameter int WIDTH_A = DEF_WIDTH_A,
    parameter int WIDTH_B = DEF_WIDTH_B
) (
    input  logic [WIDTH_A:0]   i_hi,
    input  logic [WIDTH_B-1:0] i_lo,
    input  logic [WIDTH_A-1:0] i_a,
    output logic [WIDTH_A:0]   o_hi,
    output logic [WIDTH_B-1:0] o_lo
);
    logic [WIDTH_A:0] w_sum;

    // hi stays below 2^WIDTH_A between steps, so the sum cannot exceed WIDTH_A+1 bits.
    assign w_sum = i_hi + (i_lo[0] ? {1'b0, i_a} : '0);
    assign o_hi  = {1'b0, w_sum[WIDTH_A:1]};
    assign o_lo  = {w_sum[0], i_lo[WIDTH_B-1:1]};

endmodule

// File: rtl/fixed_multiplier.sv
// Sequential multiply-accumulate Product = A*B + C, retiring one multiplier bit per clock.
// Define FIXED_MULTIPLIER_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module fixed_multiplier
    import fixed_arith_pkg::*;
#(
    parameter int WIDTH_A = DEF_WIDTH_A,
    parameter int WIDTH_B = DEF_WIDTH_B
) (
    input  logic              clock,
    input  logic              reset_n,
    fixed_multiplier_if.slave mul_bus,
    output state_t            o_state
);
    localparam int CW = count_width(WIDTH_B);
    localparam int RW = WIDTH_A + WIDTH_B;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_count;
    logic [WIDTH_A-1:0] r_a;
    logic [WIDTH_A:0]   r_hi;
    logic [WIDTH_B-1:0] r_lo;
    logic [RW-1:0]      r_product;

    logic [WIDTH_A:0]   w_hi_next;
    logic [WIDTH_B-1:0] w_lo_next;
    logic [CW-1:0]      w_count_next;
    logic               w_accept;
    logic               w_last;
    logic               w_busy;
    logic               w_done;
    logic [RW-1:0]      w_result;

    fixed_mul_step #(
        .WIDTH_A (WIDTH_A),
        .WIDTH_B (WIDTH_B)
    ) u_step (
        .i_hi (r_hi),
        .i_lo (r_lo),
        .i_a  (r_a),
        .o_hi (w_hi_next),
        .o_lo (w_lo_next)
    );

    assign w_count_next = r_count + CW'(1);

`ifdef FIXED_MULTIPLIER_EARLY_TERM_EN
    logic [WIDTH_B-1:0] w_rem_mask;
    logic [CW-1:0]      w_align;

    // After this step the low (WIDTH_B - count_next) bits of lo are still unretired multiplier
    // bits; once they are all zero the remaining steps would only shift, so do them in one go.
    assign w_rem_mask = {WIDTH_B{1'b1}} >> w_count_next;
    assign w_align    = CW'(WIDTH_B) - w_count_next;
    assign w_last     = ((w_lo_next & w_rem_mask) == '0);
    assign w_result   = {w_hi_next[WIDTH_A-1:0], w_lo_next} >> w_align;
`else
    assign w_last     = (w_count_next == CW'(WIDTH_B));
    assign w_result   = {w_hi_next[WIDTH_A-1:0], w_lo_next};
`endif

    assign w_accept = mul_bus.init && (r_state != RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (mul_bus.init) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = mul_bus.init ? RUN : IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_a       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_count <= '0;
            r_a     <= mul_bus.inMultiplicand;
            r_hi    <= {{(WIDTH_A + 1 - WIDTH_B){1'b0}}, mul_bus.inAddend};
            r_lo    <= mul_bus.inMultiplier;
        end else if (r_state == RUN) begin
            r_count <= w_count_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            // Product only ever takes a finished result, never a partial sum.
            if (w_last) begin
                r_product <= w_result;
            end
        end
    end

    assign mul_bus.Product = r_product;
    assign mul_bus.busy    = w_busy;
    assign mul_bus.done    = w_done;
    assign o_state         = r_state;

endmodule

// File: tb/tb_fixed_multiplier.sv
// Self-checking bench for fixed_multiplier: behavioural MAC model, per-cycle compare, directed and random ops.
// Honours FIXED_MULTIPLIER_EARLY_TERM_EN for the expected latency.
module tb_fixed_multiplier;
  import fixed_arith_pkg::*;

  localparam int WA = 32;
  localparam int WB = 16;
  localparam int W  = WA + WB;

`ifdef FIXED_MULTIPLIER_EARLY_TERM_EN
  localparam int LAT_B7 = 3;
  localparam int LAT_B1 = 1;
`else
  localparam int LAT_B7 = 16;
  localparam int LAT_B1 = 16;
`endif

  // clock / reset
  logic   clock   = 1'b0;
  logic   reset_n = 1'b0;
  state_t dut_state;

  always #5 clock = ~clock;

  fixed_multiplier_if #(.WIDTH_A(WA), .WIDTH_B(WB)) mul_bus ();

  fixed_multiplier #(
    .WIDTH_A (WA),
    .WIDTH_B (WB)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .mul_bus (mul_bus),
    .o_state (dut_state)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  always @(posedge clock) cyc++;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // behavioural reference
  function automatic logic [W-1:0] mac(logic [WA-1:0] a, logic [WB-1:0] b, logic [WB-1:0] c);
    logic [63:0] p;
    p = 64'(a) * 64'(b) + 64'(c);
    return p[W-1:0];
  endfunction

  function automatic int lat(logic [WB-1:0] b);
    int h;
    h = 0;
`ifdef FIXED_MULTIPLIER_EARLY_TERM_EN
    for (int i = 0; i < WB; i++) if (b[i]) h = i + 1;
    return (h < 1) ? 1 : h;
`else
    h = WB + 0 * int'(b[0]);
    return h;
`endif
  endfunction

  // scoreboard: results of accepted ops, retired in order as the model completes them
  logic [W-1:0] exp_q[$];
  bit           m_busy    = 1'b0;
  bit           m_done    = 1'b0;
  int           m_left    = 0;
  logic [W-1:0] m_product = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_left    = 0;
      m_product = '0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (exp_q.size() > 0) m_product = exp_q.pop_front();
        end
      end else if (mul_bus.init) begin
        m_busy = 1'b1;
        m_left = lat(mul_bus.inMultiplier);
        exp_q.push_back(mac(mul_bus.inMultiplicand, mul_bus.inMultiplier, mul_bus.inAddend));
      end
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clock) begin
    if (chk_en) begin
      state_t exp_st;
      exp_st = m_busy ? RUN : (m_done ? DONE : IDLE);
      check("busy",    64'(mul_bus.busy),    64'(m_busy));
      check("done",    64'(mul_bus.done),    64'(m_done));
      check("product", 64'(mul_bus.Product), 64'(m_product));
      check("state",   64'(dut_state),       64'(exp_st));
    end
  end

  // driver tasks (called at a negedge)
  task automatic scramble_ops();
    mul_bus.inMultiplicand = $urandom();
    mul_bus.inMultiplier   = 16'($urandom());
    mul_bus.inAddend       = 16'($urandom());
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (mul_bus.done !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", 64'(mul_bus.done), 64'd1);
  endtask

  task automatic do_op(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic [WB-1:0] c,
                       output logic [W-1:0] prod, output int n);
    @(negedge clock);
    mul_bus.init           = 1'b1;
    mul_bus.inMultiplicand = a;
    mul_bus.inMultiplier   = b;
    mul_bus.inAddend       = c;
    @(negedge clock);
    mul_bus.init = 1'b0;
    scramble_ops();
    wait_done(n);
    prod = mul_bus.Product;
  endtask

  initial begin
    logic [W-1:0]  prod;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [WB-1:0] c;
    int n;
    int t1;
    int pulses;

    mul_bus.init           = 1'b0;
    mul_bus.inMultiplicand = '0;
    mul_bus.inMultiplier   = '0;
    mul_bus.inAddend       = '0;
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    @(negedge clock);
    check("reset_product", 64'(mul_bus.Product), 64'd0);
    check("reset_state",   64'(dut_state),       64'(IDLE));
    #2 reset_n = 1'b1;

    // basic op and one-cycle done
    do_op(32'd100, 16'd7, 16'd3, prod, n);
    check("basic_product", 64'(prod), 64'd703);
    check("basic_latency", 64'(n),    64'(LAT_B7));
    @(negedge clock);
    check("basic_done_width", 64'(mul_bus.done), 64'd0);

    // all-ones operands: largest result, no wrap
    do_op(32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, prod, n);
    check("max_product", 64'(prod), 64'hFFFF_0000_0000);

    // divider round-trip
    do_op(32'h0001_0004, 16'h1234, 16'h0DA8, prod, n);
    check("roundtrip_product", 64'(prod), 64'h0000_1234_5678);

    // init held through RUN with changing operands, then back-to-back accept in DONE
    @(negedge clock);
    mul_bus.init           = 1'b1;
    mul_bus.inMultiplicand = 32'd100;
    mul_bus.inMultiplier   = 16'd7;
    mul_bus.inAddend       = 16'd3;
    @(negedge clock);
    mul_bus.inMultiplicand = $urandom();
    mul_bus.inMultiplier   = 16'h8000 | 16'($urandom());
    mul_bus.inAddend       = 16'($urandom());
    wait_done(n);
    check("hold_first_product", 64'(mul_bus.Product), 64'd703);
    t1 = cyc;
    @(negedge clock);
    mul_bus.init = 1'b0;
    scramble_ops();
    wait_done(n);
    check("hold_done_gap", 64'(cyc - t1), 64'd17);

    // reset in the middle of RUN aborts without a done pulse
    @(negedge clock);
    mul_bus.init           = 1'b1;
    mul_bus.inMultiplicand = $urandom();
    mul_bus.inMultiplier   = 16'h8000 | 16'($urandom());
    mul_bus.inAddend       = 16'($urandom());
    @(negedge clock);
    mul_bus.init = 1'b0;
    repeat (7) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy",    64'(mul_bus.busy),    64'd0);
    check("abort_product", 64'(mul_bus.Product), 64'd0);
    check("abort_state",   64'(dut_state),       64'(IDLE));
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clock);
      if (mul_bus.done === 1'b1) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);

    // short multiplier: early finish when enabled, full latency otherwise
    do_op(32'd5, 16'd1, 16'd0, prod, n);
    check("short_product", 64'(prod), 64'd5);
    check("short_latency", 64'(n),    64'(LAT_B1));

    // random ops, with small multipliers mixed in
    for (int i = 0; i < 30; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom());
      c = 16'($urandom());
      do_op(a, b, c, prod, n);
      check("rand_product", 64'(prod), 64'(mac(a, b, c)));
      check("rand_latency", 64'(n),    64'(lat(b)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
